mem_port_arbiter: RTL

- Shares one single-port 64-bit unified memory between the IF stage (instruction reads) and the MEM stage (loads/stores) of the 5-stage RV64 pipeline.
- Each request is sequenced through a fixed-latency memory access, and a stall is returned to whichever stage is waiting.
- The pipeline controller ORs if_stall/d_stall into its existing NOP/freeze logic.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_lat_cnt.sv | 36 +++
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and helpers for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  localparam int CNT_W = 4;

  // Instruction words live in either half of the fetched doubleword.
  function automatic logic [31:0] sel_word(input logic [63:0] dw, input logic hi);
    return hi ? dw[63:32] : dw[31:0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_cnt.sv
// rtl/mem_port_arbiter_lat_cnt.sv - loadable down-counter with done flag (arb_lat_cnt)
module arb_lat_cnt
  import mem_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter sharing one fixed-latency 64-bit memory port
// Optional MEM_ARB_FAIR_EN: caps consecutive data grants while a fetch is pending.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 2
`ifdef MEM_ARB_FAIR_EN
  ,
  parameter int FAIR_LIMIT = 4
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_wstrb,
  output logic [63:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic [63:0] mem_rdata
);

  arb_state_e  state_q, state_d;
  arb_owner_e  owner_q, owner_d;
  logic        sel_hi_q, sel_hi_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic [63:0] d_rdata_q, d_rdata_d;
  logic        d_valid_q, d_valid_d;

  logic             gnt_data, gnt_inst;
  logic             cnt_load, cnt_dec, cnt_done;
  logic [CNT_W-1:0] cnt_unused;
  logic             unused_addr_bits;

  // Low address bits are the load/store unit's business; memory is doubleword addressed.
  assign unused_addr_bits = ^{d_addr[2:0], if_addr[1:0]};

`ifdef MEM_ARB_FAIR_EN
  logic [CNT_W-1:0] fair_cnt_q, fair_cnt_d;
  logic             fair_block;

  assign fair_block = if_req && (fair_cnt_q >= CNT_W'(FAIR_LIMIT));
  assign gnt_data   = d_req && !fair_block;

  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if ((state_q == IDLE) && (gnt_data || gnt_inst)) begin
      if (gnt_inst || !if_req) begin
        fair_cnt_d = '0;
      end else if (fair_cnt_q < CNT_W'(FAIR_LIMIT)) begin
        fair_cnt_d = fair_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fair_cnt_q <= '0;
    end else begin
      fair_cnt_q <= fair_cnt_d;
    end
  end
`else
  assign gnt_data = d_req;
`endif

  assign gnt_inst = if_req && !gnt_data;

  arb_lat_cnt u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(MEM_LAT)),
    .dec      (cnt_dec),
    .count    (cnt_unused),
    .done     (cnt_done)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    sel_hi_d    = sel_hi_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d  = if_rdata_q;
    if_valid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_valid_d   = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_data || gnt_inst) begin
          owner_d     = gnt_data ? OWN_D : OWN_I;
          sel_hi_d    = if_addr[2];
          mem_en_d    = 1'b1;
          mem_we_d    = gnt_data && d_we;
          mem_addr_d  = gnt_data ? {d_addr[31:3], 3'b000} : {if_addr[31:3], 3'b000};
          mem_wdata_d = gnt_data ? d_wdata : '0;
          mem_wstrb_d = gnt_data ? d_wstrb : '0;
          cnt_load    = 1'b1;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        // Counter hits zero in the cycle mem_rdata is valid; results land as RESP begins.
        if (cnt_done) begin
          state_d = RESP;
          if (owner_q == OWN_I) begin
            if_rdata_d = sel_word(mem_rdata, sel_hi_q);
            if_valid_d = 1'b1;
          end else begin
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
            d_valid_d = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      sel_hi_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      sel_hi_q    <= sel_hi_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_valid_q   <= d_valid_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;

  assign if_stall  = if_req && !if_valid_q;
  assign d_stall   = d_req && !d_valid_q;

endmodule
